// File: rtl/counter_mod_async_reset.sv
// Modulo-N up/down counter with wrap or saturate limit, sync clear/load and a registered
// terminal-count pulse. Define COUNTER_PRESCALER_EN to count only every PRESCALE-th enabled cycle.
module counter_mod_async_reset #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] result,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  // One bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);
  localparam bit               Sat    = (SATURATE != 0);

  logic [WIDTH-1:0] result_q, result_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             count_step;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] up_next, dn_next, load_lim;

`ifdef COUNTER_PRESCALER_EN
  localparam int unsigned   PhaseW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(PRESCALE - 1);
  localparam logic [PhaseW-1:0] PhaseOne = PhaseW'(1);

  logic [PhaseW-1:0] phase_q, phase_d;

  // Phase advances only on enabled cycles and restarts on clear/load.
  always_comb begin
    phase_d = phase_q;
    tick    = (phase_q == PhaseMax);
    if (clear || load) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = tick ? '0 : phase_q + PhaseOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  localparam int unsigned unused_prescale = PRESCALE;

  assign tick = 1'b1;
`endif

  always_comb begin
    at_max     = (result_q == MaxVal);
    at_zero    = (result_q == '0);
    count_step = en & ~clear & ~load & tick;
    up_next    = at_max  ? (Sat ? MaxVal : '0) : result_q + One;
    dn_next    = at_zero ? (Sat ? '0 : MaxVal) : result_q - One;
    load_lim   = ({1'b0, load_value} < ModExt) ? load_value : MaxVal;
  end

  always_comb begin
    result_d = result_q;
    tc_d     = 1'b0;
    if (clear) begin
      result_d = '0;
    end else if (load) begin
      result_d = load_lim;
    end else if (count_step) begin
      result_d = up ? up_next : dn_next;
      tc_d     = up ? at_max : at_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      tc_q     <= tc_d;
    end
  end

  assign result = result_q;
  assign tc     = tc_q;

endmodule

// File: tb/tb_counter_mod_async_reset.sv
// Bench for counter_mod_async_reset: three parameterisations checked every cycle against an
// arithmetic model, plus literal expectations for the documented scenarios.
module tb_counter_mod_async_reset;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       en = 1'b0;
  logic       up = 1'b1;

  logic [7:0] res_a, res_b;
  logic [3:0] res_c;
  logic       tc_a, tc_b, tc_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_mod_async_reset #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .PRESCALE(4)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .up(up), .result(res_a), .tc(tc_a)
  );

  counter_mod_async_reset #(.WIDTH(8), .MODULUS(10), .SATURATE(1), .PRESCALE(4)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .up(up), .result(res_b), .tc(tc_b)
  );

  counter_mod_async_reset #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(4)) u_w4 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value[3:0]),
    .en(en), .up(up), .result(res_c), .tc(tc_c)
  );

  // Model: per-instance modulus, limit mode and load mask.
  int mod_v[3]  = '{10, 10, 16};
  int sat_v[3]  = '{0, 1, 0};
  int mask_v[3] = '{255, 255, 15};
  int m_res[3]  = '{0, 0, 0};
  int m_tc[3]   = '{0, 0, 0};
  int m_ph[3]   = '{0, 0, 0};
  localparam int Prescale = 4;

  function automatic int model_tick(int ph);
`ifdef COUNTER_PRESCALER_EN
    return (ph == Prescale - 1) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  function automatic int model_next(int r, int m, int s, int lv, bit clr, bit ld, bit stp,
                                    bit u);
    if (clr) return 0;
    if (ld) return (lv < m) ? lv : m - 1;
    if (!stp) return r;
    if (u) return (r == m - 1) ? (s != 0 ? r : 0) : r + 1;
    return (r == 0) ? (s != 0 ? 0 : m - 1) : r - 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_res[i] <= 0;
        m_tc[i]  <= 0;
        m_ph[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit stp;
        stp = en && !clear && !load && (model_tick(m_ph[i]) != 0);
        m_res[i] <= model_next(m_res[i], mod_v[i], sat_v[i], int'(load_value) & mask_v[i],
                               clear, load, stp, up);
        m_tc[i]  <= (stp && (up ? (m_res[i] == mod_v[i] - 1) : (m_res[i] == 0))) ? 1 : 0;
        if (clear || load) m_ph[i] <= 0;
        else if (en) m_ph[i] <= (m_ph[i] + 1) % Prescale;
      end
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_res_wrap", int'(res_a), m_res[0]);
    check("model_tc_wrap", int'(tc_a), m_tc[0]);
    check("model_res_sat", int'(res_b), m_res[1]);
    check("model_tc_sat", int'(tc_b), m_tc[1]);
    check("model_res_w4", int'(res_c), m_res[2]);
    check("model_tc_w4", int'(tc_c), m_tc[2]);
  end

  // Drive a vector on the falling edge; return just after the following rising edge.
  task automatic drive(bit c, bit l, int lv, bit e, bit u);
    @(negedge clk);
    clear      = c;
    load       = l;
    load_value = 8'(lv);
    en         = e;
    up         = u;
    @(posedge clk);
    #2;
  endtask

  int exp_dn[4] = '{1, 0, 0, 0};
  int exp_dtc[4] = '{0, 0, 1, 1};

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset_res_wrap", int'(res_a), 0);
    check("reset_tc_wrap", int'(tc_a), 0);
    check("reset_res_w4", int'(res_c), 0);
    reset = 1'b0;

`ifdef COUNTER_PRESCALER_EN
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 1, 1);
      check("prescale_res", int'(res_a), k / 4);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    check("prescale_gap_hold", int'(res_a), 2);
`else
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 1, 1);
      check("wrap_up_res", int'(res_a), k % 10);
      check("wrap_up_tc", int'(tc_a), (k == 10) ? 1 : 0);
    end
`endif

    drive(0, 1, 2, 0, 1);
    check("load2_sat", int'(res_b), 2);
`ifndef COUNTER_PRESCALER_EN
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0);
      check("sat_down_res", int'(res_b), exp_dn[k]);
      check("sat_down_tc", int'(tc_b), exp_dtc[k]);
    end
`endif

    drive(0, 1, 5, 0, 1);
    check("load5", int'(res_a), 5);
    drive(1, 1, 9, 1, 1);
    check("clear_over_load_res", int'(res_a), 0);
    check("clear_over_load_tc", int'(tc_a), 0);
    drive(0, 1, 15, 0, 1);
    check("load15_limited", int'(res_a), 9);
    check("load15_w4", int'(res_c), 15);

    drive(0, 1, 7, 0, 1);
    check("load7", int'(res_a), 7);
    @(negedge clk);
    clear = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_reset_res", int'(res_a), 0);
    check("async_reset_tc", int'(tc_a), 0);
    #1 reset = 1'b0;
`ifndef COUNTER_PRESCALER_EN
    drive(0, 0, 0, 1, 1);
    check("resume_after_reset", int'(res_a), 1);
`endif

    drive(0, 1, 15, 0, 1);
    check("load15_w4_again", int'(res_c), 15);
`ifndef COUNTER_PRESCALER_EN
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("toggle_res_w4", int'(res_c), (k % 2 == 0) ? 0 : 15);
      check("toggle_tc_w4", int'(tc_c), 1);
    end
    drive(0, 0, 0, 0, 1);
    check("hold_res_w4", int'(res_c), 15);
    check("hold_tc_w4", int'(tc_c), 0);
`endif

    for (int i = 0; i < 40; i++) begin
      drive((i == 17), (i == 25 || i == 31), (i == 25) ? 200 : 6, (i % 3 != 0),
            ((i / 5) % 2 == 0));
    end

    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
